// File: rtl/aes128_decrypt_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, byte substitution, round primitives,
// the key-expansion step and the decrypt FSM state type.
package aes128_decrypt_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_READY, S_RUN, S_DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_step(input logic [127:0] prev, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3;
    w0 = prev[31:0] ^ sub_word(rot_word(prev[127:96])) ^ {24'h0, rcon(r)};
    w1 = prev[63:32] ^ w0;
    w2 = prev[95:64] ^ w1;
    w3 = prev[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  // byte r+4c is row r, column c; row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
    return s ^ rk;
  endfunction

endpackage

// File: rtl/aes_key_sched.sv
// AES-128 key schedule: captures round key 0 on load, then one round key per cycle
// for 10 cycles; last flags the final write, done holds until the next load or reset.
module aes_key_sched
  import aes128_decrypt_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         last,
  output logic         done
);

  logic [127:0] rk [0:NR];
  logic [3:0]   cnt;
  logic         busy;

  assign last   = busy && (cnt == 4'(NR));
  assign rd_key = rk[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 4'd0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= 4'd1;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (last) begin
        cnt  <= 4'd0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // storage is left unreset; done gates every use of it
  always_ff @(posedge clk) begin
    if (load)
      rk[0] <= key;
    else if (busy)
      rk[cnt] <= expand_step(rk[cnt - 4'd1], cnt);
  end

endmodule

// File: rtl/aes128_decrypt.sv
// AES-128 decryptor: one inverse round per cycle, pt_valid 10 edges after ct accept.
// pt is held in DONE until pt_ready; a new key always wins over a pending ct.
module aes128_decrypt
  import aes128_decrypt_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] ct,
  input  logic         ct_valid,
  output logic         ct_ready,
  output logic [127:0] pt,
  output logic         pt_valid,
  input  logic         pt_ready
);

  state_t       state;
  logic [3:0]   round_cnt;
  logic [127:0] st;
  logic [127:0] pt_q;
  logic         pt_valid_q;

  logic         key_fire, ct_fire;
  logic         sched_last, sched_done;
  logic [3:0]   rd_idx;
  logic [127:0] rk_rd, round_core, round_out;

  assign key_ready = (state == S_IDLE) || (state == S_READY);
  assign ct_ready  = (state == S_READY) && !key_valid;
  assign key_fire  = key_valid && key_ready;
  assign ct_fire   = ct_valid && ct_ready && sched_done;
  assign pt        = pt_q;
  assign pt_valid  = pt_valid_q;

  // READY needs rk[10] for the initial whitening; RUN walks down from 9
  assign rd_idx = (state == S_RUN) ? round_cnt : 4'(NR);

  aes_key_sched u_sched (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (key_fire),
    .key    (key),
    .rd_idx (rd_idx),
    .rd_key (rk_rd),
    .last   (sched_last),
    .done   (sched_done)
  );

  assign round_core = add_round_key(inv_sub_bytes(inv_shift_rows(st)), rk_rd);
  assign round_out  = inv_mix_columns(round_core);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      round_cnt  <= 4'd0;
      st         <= '0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_fire) state <= S_EXPAND;
        end
        S_EXPAND: begin
          if (sched_last) state <= S_READY;
        end
        S_READY: begin
          if (key_fire) begin
            state <= S_EXPAND;
          end else if (ct_fire) begin
            st        <= add_round_key(ct, rk_rd);
            round_cnt <= 4'(NR - 1);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (round_cnt == 4'd0) begin
            pt_q       <= round_core;
            pt_valid_q <= 1'b1;
            state      <= S_DONE;
          end else begin
            st        <= round_out;
            round_cnt <= round_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (pt_ready) begin
            pt_q       <= '0;
            pt_valid_q <= 1'b0;
            state      <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt.sv
// Bench for aes128_decrypt: random keys/blocks are encrypted by a forward-cipher
// model here and the DUT must recover the plaintext, plus the FIPS-197 vectors.
module tb_aes128_decrypt;

  logic         clk;
  logic         rst_n;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] ct;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] pt;
  logic         pt_valid;
  logic         pt_ready;

  int checks;
  int failures;

  logic [7:0]   sbox_t [256];
  logic [127:0] m_rk   [11];

  aes128_decrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .ct        (ct),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .pt        (pt),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x};
    t = t >> (8 - n);
    return t[7:0];
  endfunction

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] from_fips(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[7:0] = t[7:0] ^ rc;
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] p);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = p ^ m_rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox_t[s[8*i +: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[8*(w+4*c) +: 8] = s[8*(w+4*((c+w)%4)) +: 8];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
          t[32*c +: 8]    = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          t[32*c+8 +: 8]  = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          t[32*c+16 +: 8] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          t[32*c+24 +: 8] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end
        s = t;
      end
      s = s ^ m_rk[r];
    end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input string tag);
    int n;
    key = k;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 100) begin tick(); n++; end
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_key_accept: key_ready=%0b required 1", tag, key_ready);
    end
    tick();
    key_valid = 1'b0;
    n = 0;
    while (!key_ready && n < 40) begin
      checks++;
      if (ct_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_expand_ct_ready: ct_ready=%0b required 0", tag, ct_ready);
      end
      tick();
      n++;
    end
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL %s_expand_len: cycles=%0d required 10", tag, n);
    end
    model_expand(k);
  endtask

  task automatic finish_block(input logic [127:0] exp_pt, input int stall, input string tag);
    int n;
    logic [127:0] held;
    n = 0;
    while (!pt_valid && n < 40) begin
      checks++;
      if (pt !== '0) begin
        failures++;
        $display("FAIL %s_pt_zero: pt=%h required 0", tag, pt);
      end
      pt_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    pt_ready = 1'b0;
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL %s_latency: edges=%0d required 10", tag, n);
    end
    checks++;
    if (pt !== exp_pt) begin
      failures++;
      $display("FAIL %s_data: pt=%h required %h", tag, pt, exp_pt);
    end
    held = pt;
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++;
      if (pt_valid !== 1'b1 || pt !== held) begin
        failures++;
        $display("FAIL %s_hold: pt_valid=%0b pt=%h required 1 %h", tag, pt_valid, pt, held);
      end
      checks++;
      if (ct_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold_ct_ready: ct_ready=%0b required 0", tag, ct_ready);
      end
    end
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    checks++;
    if (pt_valid !== 1'b0 || pt !== '0) begin
      failures++;
      $display("FAIL %s_release: pt_valid=%0b pt=%h required 0 0", tag, pt_valid, pt);
    end
    checks++;
    if (ct_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_next_ready: ct_ready=%0b required 1", tag, ct_ready);
    end
  endtask

  task automatic do_block(input logic [127:0] c, input logic [127:0] exp_pt,
                          input int stall, input string tag);
    int n;
    ct = c;
    ct_valid = 1'b1;
    n = 0;
    while (!ct_ready && n < 100) begin tick(); n++; end
    checks++;
    if (ct_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ct_accept: ct_ready=%0b required 1", tag, ct_ready);
    end
    tick();
    ct_valid = 1'b0;
    ct = rand128();
    finish_block(exp_pt, stall, tag);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_key_ready: got %0b required 1", key_ready); end
    checks++;
    if (ct_ready !== 1'b0) begin failures++; $display("FAIL reset_ct_ready: got %0b required 0", ct_ready); end
    checks++;
    if (pt_valid !== 1'b0) begin failures++; $display("FAIL reset_pt_valid: got %0b required 0", pt_valid); end
    checks++;
    if (pt !== '0) begin failures++; $display("FAIL reset_pt: got %h required 0", pt); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_key();
    ct = rand128();
    ct_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (ct_ready !== 1'b0 || pt_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_key: ct_ready=%0b pt_valid=%0b required 0 0", ct_ready, pt_valid);
      end
    end
    ct_valid = 1'b0;
  endtask

  task automatic test_fips_vectors();
    load_key(from_fips(128'h000102030405060708090a0b0c0d0e0f), "fips_c1");
    do_block(from_fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
             from_fips(128'h00112233445566778899aabbccddeeff), 0, "fips_c1");
    load_key(from_fips(128'h2b7e151628aed2a6abf7158809cf4f3c), "fips_b");
    do_block(from_fips(128'h3925841d02dc09fbdc118597196a0b32),
             from_fips(128'h3243f6a8885a308d313198a2e0370734), 0, "fips_b");
  endtask

  task automatic test_hold();
    logic [127:0] p;
    p = rand128();
    do_block(model_encrypt(p), p, 5, "hold");
  endtask

  task automatic test_key_priority();
    logic [127:0] k2, p, c;
    int n;
    k2 = rand128();
    p  = rand128();
    model_expand(k2);
    c = model_encrypt(p);
    key = k2;
    ct = c;
    key_valid = 1'b1;
    ct_valid = 1'b1;
    #1;
    checks++;
    if (ct_ready !== 1'b0) begin failures++; $display("FAIL prio_ct_ready: got %0b required 0", ct_ready); end
    tick();
    key_valid = 1'b0;
    n = 0;
    while (!ct_ready && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 10) begin failures++; $display("FAIL prio_expand_len: cycles=%0d required 10", n); end
    tick();
    ct_valid = 1'b0;
    finish_block(p, 0, "prio");
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] p;
    p = rand128();
    ct = model_encrypt(p);
    ct_valid = 1'b1;
    tick();
    ct_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pt_valid !== 1'b0 || pt !== '0) begin
      failures++;
      $display("FAIL midrst_pt: pt_valid=%0b pt=%h required 0 0", pt_valid, pt);
    end
    checks++;
    if (key_ready !== 1'b1 || ct_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ready: key_ready=%0b ct_ready=%0b required 1 0", key_ready, ct_ready);
    end
    tick();
    rst_n = 1'b1;
    ct_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (ct_ready !== 1'b0 || pt_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_ct: ct_ready=%0b pt_valid=%0b required 0 0", ct_ready, pt_valid);
      end
    end
    ct_valid = 1'b0;
    load_key(rand128(), "midrst");
    p = rand128();
    do_block(model_encrypt(p), p, 1, "midrst");
  endtask

  task automatic test_random();
    logic [127:0] p;
    for (int k = 0; k < 3; k++) begin
      load_key(rand128(), "rand");
      for (int b = 0; b < 4; b++) begin
        p = rand128();
        do_block(model_encrypt(p), p, int'($urandom_range(0, 3)), "rand");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p;
    for (int b = 0; b < 3; b++) begin
      p = rand128();
      do_block(model_encrypt(p), p, 0, "b2b");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    key = '0;
    key_valid = 1'b0;
    ct = '0;
    ct_valid = 1'b0;
    pt_ready = 1'b0;
    build_sbox();
    test_reset();
    test_no_key();
    test_fips_vectors();
    test_hold();
    test_key_priority();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
